// File: rtl/mem_rw_arbiter_if.sv
// Request/response handshakes for both core ports plus the backing-memory strobe bus.
// The arbiter uses the slave view; requesters and the memory helper use the master view.
interface mem_rw_arbiter_if;
  logic        p0_req_valid;
  logic        p0_req_ready;
  logic [63:0] p0_req_addr;
  logic        p0_resp_valid;
  logic        p0_resp_ready;
  logic [63:0] p0_resp_rdata;
  logic        p0_resp_err;

  logic        p1_req_valid;
  logic        p1_req_ready;
  logic        p1_req_wen;
  logic [63:0] p1_req_addr;
  logic [63:0] p1_req_wdata;
  logic [7:0]  p1_req_wstrb;
  logic        p1_resp_valid;
  logic        p1_resp_ready;
  logic [63:0] p1_resp_rdata;
  logic        p1_resp_err;

  logic        mem_r_enable;
  logic [63:0] mem_r_index;
  logic [63:0] mem_r_data;
  logic        mem_w_enable;
  logic [63:0] mem_w_index;
  logic [63:0] mem_w_data;
  logic [63:0] mem_w_mask;

  modport slave (
    input  p0_req_valid, p0_req_addr, p0_resp_ready,
    input  p1_req_valid, p1_req_wen, p1_req_addr, p1_req_wdata, p1_req_wstrb, p1_resp_ready,
    input  mem_r_data,
    output p0_req_ready, p0_resp_valid, p0_resp_rdata, p0_resp_err,
    output p1_req_ready, p1_resp_valid, p1_resp_rdata, p1_resp_err,
    output mem_r_enable, mem_r_index, mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
  );

  modport master (
    output p0_req_valid, p0_req_addr, p0_resp_ready,
    output p1_req_valid, p1_req_wen, p1_req_addr, p1_req_wdata, p1_req_wstrb, p1_resp_ready,
    output mem_r_data,
    input  p0_req_ready, p0_resp_valid, p0_resp_rdata, p0_resp_err,
    input  p1_req_ready, p1_resp_valid, p1_resp_rdata, p1_resp_err,
    input  mem_r_enable, mem_r_index, mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
  );
endinterface

// File: rtl/mem_rw_arbiter.sv
// Round-robin two-port controller for the single-port 64-bit backing memory:
// one memory access per transaction, response held until the requester accepts it.
module mem_rw_arbiter #(
  parameter logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h0000_0000_8000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  mem_rw_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        rr_ptr;
  logic        port_q;
  logic        wen_q;
  logic        err_q;
  logic        r_en_q;
  logic        w_en_q;
  logic        resp_valid_q;
  logic [63:0] index_q;
  logic [63:0] wdata_q;
  logic [63:0] mask_q;

  logic        grant0;
  logic        grant1;
  logic [63:0] sel_addr;
  logic [63:0] offset;
  logic        sel_wen;
  logic        in_range;
  logic [63:0] exp_mask;
  logic [63:0] rdata_sel;

  always_comb begin
    grant1   = bus.p1_req_valid & (~bus.p0_req_valid | rr_ptr);
    grant0   = bus.p0_req_valid & ~grant1;
    sel_addr = grant1 ? bus.p1_req_addr : bus.p0_req_addr;
    sel_wen  = grant1 & bus.p1_req_wen;
    offset   = sel_addr - MEM_BASE;
    // Lower bound is tested first, so the offset comparison never sees a wrapped value.
    in_range = (sel_addr >= MEM_BASE) && (offset < MEM_BYTES);
    exp_mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      exp_mask[i*8 +: 8] = {8{bus.p1_req_wstrb[i]}};
    end
  end

  // Ready is gated by reset so nothing is granted while reset is held.
  assign bus.p0_req_ready = reset_n & (state == IDLE) & grant0;
  assign bus.p1_req_ready = reset_n & (state == IDLE) & grant1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      port_q       <= 1'b0;
      wen_q        <= 1'b0;
      err_q        <= 1'b0;
      r_en_q       <= 1'b0;
      w_en_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      index_q      <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            port_q  <= grant1;
            wen_q   <= sel_wen;
            err_q   <= ~in_range;
            index_q <= offset >> 3;
            wdata_q <= grant1 ? bus.p1_req_wdata : '0;
            mask_q  <= grant1 ? exp_mask : '0;
            r_en_q  <= in_range & ~sel_wen;
            w_en_q  <= in_range & sel_wen;
            rr_ptr  <= ~grant1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_en_q       <= 1'b0;
          w_en_q       <= 1'b0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (port_q ? bus.p1_resp_ready : bus.p0_resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory read data is registered by the helper, so it is already stable throughout RESP.
  assign rdata_sel = (resp_valid_q & ~wen_q & ~err_q) ? bus.mem_r_data : '0;

  assign bus.p0_resp_valid = resp_valid_q & ~port_q;
  assign bus.p0_resp_rdata = ~port_q ? rdata_sel : '0;
  assign bus.p0_resp_err   = resp_valid_q & ~port_q & err_q;
  assign bus.p1_resp_valid = resp_valid_q & port_q;
  assign bus.p1_resp_rdata = port_q ? rdata_sel : '0;
  assign bus.p1_resp_err   = resp_valid_q & port_q & err_q;

  assign bus.mem_r_enable = r_en_q;
  assign bus.mem_r_index  = index_q;
  assign bus.mem_w_enable = w_en_q;
  assign bus.mem_w_index  = index_q;
  assign bus.mem_w_data   = wdata_q;
  assign bus.mem_w_mask   = mask_q;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Randomized scoreboard bench for mem_rw_arbiter: a transaction-level model predicts grants,
// memory strobes and responses; a separate monitor compares each presented response.
module tb_mem_rw_arbiter;
  localparam logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MEM_BYTES = 64'h0000_0000_8000_0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_rw_arbiter_if bus();

  mem_rw_arbiter #(.MEM_BASE(MEM_BASE), .MEM_BYTES(MEM_BYTES)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    bit          port;
    logic [63:0] rdata;
    bit          err;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req1_t;

  int vectors = 0;
  int miscompares = 0;

  resp_t       exp_q[$];
  logic [63:0] dir0[$];
  req1_t       dir1[$];
  logic [63:0] env_mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  bit          run = 1'b0;
  bit          busy = 1'b0;
  int          phase = 0;
  bit          cur_port = 1'b0;
  bit          pref = 1'b0;
  bit          exp_r, exp_w;
  logic [63:0] exp_idx, exp_data, exp_mask;
  int          acc0 = 0, acc1 = 0;
  int          seen0 = 0, seen1 = 0;
  int          hold_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] idx);
    return {idx[31:0] ^ 32'hA5A5_5A5A, ~idx[31:0] + 32'h0000_1234};
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  function automatic logic [63:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    int unsigned j;
    if (k <= 6) return MEM_BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
    if (k == 7) return MEM_BASE + MEM_BYTES - 64'd8 + 64'($urandom_range(0, 7));
    if (k == 8) return MEM_BASE - 64'd8;
    j = $urandom_range(0, 2);
    if (j == 0) return MEM_BASE + MEM_BYTES;
    if (j == 1) return 64'd0;
    return 64'hFFFF_FFFF_FFFF_FFF8;
  endfunction

  // Backing memory helper: writes apply on the strobe edge, read data returns one cycle later.
  always @(posedge clock) begin
    logic [63:0] old;
    if (bus.mem_w_enable) begin
      old = env_mem.exists(bus.mem_w_index) ? env_mem[bus.mem_w_index] : init_word(bus.mem_w_index);
      env_mem[bus.mem_w_index] = (old & ~bus.mem_w_mask) | (bus.mem_w_data & bus.mem_w_mask);
    end
    if (bus.mem_r_enable)
      bus.mem_r_data <= env_mem.exists(bus.mem_r_index) ? env_mem[bus.mem_r_index] : init_word(bus.mem_r_index);
  end

  task automatic model_accept(input bit g);
    logic [63:0] a, w;
    logic        wn;
    bit          inr;
    resp_t       e;
    a   = g ? bus.p1_req_addr : bus.p0_req_addr;
    wn  = g && bus.p1_req_wen;
    inr = ({1'b0, a} >= {1'b0, MEM_BASE}) && ({1'b0, a} < {1'b0, MEM_BASE} + {1'b0, MEM_BYTES});
    exp_idx  = (a - MEM_BASE) / 64'd8;
    exp_data = bus.p1_req_wdata;
    exp_mask = '0;
    exp_r = 1'b0;
    exp_w = 1'b0;
    e.port  = g;
    e.rdata = '0;
    e.err   = !inr;
    if (inr && wn) begin
      exp_w = 1'b1;
      w = ref_read(exp_idx);
      for (int b = 0; b < 8; b++) begin
        if (bus.p1_req_wstrb[b]) begin
          w[b*8 +: 8] = bus.p1_req_wdata[b*8 +: 8];
          exp_mask[b*8 +: 8] = 8'hFF;
        end
      end
      ref_mem[exp_idx] = w;
    end else if (inr) begin
      exp_r = 1'b1;
      e.rdata = ref_read(exp_idx);
    end
    exp_q.push_back(e);
    busy = 1'b1;
    phase = 0;
    cur_port = g;
    pref = !g;
    if (g) acc1++;
    else   acc0++;
  endtask

  // Reference model: transaction phases, grant prediction and memory-strobe expectations.
  always @(negedge clock) begin
    bit want0, want1;
    if (!reset_n) begin
      busy = 1'b0;
      phase = 0;
      pref = 1'b0;
      exp_q.delete();
    end else if (run) begin
      if (busy && phase < 2) phase++;
      check("p0_resp_valid", bus.p0_resp_valid, busy && phase == 2 && !cur_port);
      check("p1_resp_valid", bus.p1_resp_valid, busy && phase == 2 && cur_port);
      if (busy && phase == 1) begin
        check("mem_r_enable", bus.mem_r_enable, exp_r);
        check("mem_w_enable", bus.mem_w_enable, exp_w);
        if (exp_r) check("mem_r_index", bus.mem_r_index, exp_idx);
        if (exp_w) begin
          check("mem_w_index", bus.mem_w_index, exp_idx);
          check("mem_w_data", bus.mem_w_data, exp_data);
          check("mem_w_mask", bus.mem_w_mask, exp_mask);
        end
      end else begin
        check("mem_r_enable quiet", bus.mem_r_enable, 0);
        check("mem_w_enable quiet", bus.mem_w_enable, 0);
      end
      if (busy) begin
        check("p0_req_ready busy", bus.p0_req_ready, 0);
        check("p1_req_ready busy", bus.p1_req_ready, 0);
        if (phase == 2 && (cur_port ? bus.p1_resp_ready : bus.p0_resp_ready)) busy = 1'b0;
      end else begin
        want0 = bus.p0_req_valid && (!bus.p1_req_valid || !pref);
        want1 = bus.p1_req_valid && !want0;
        check("p0_req_ready", bus.p0_req_ready, want0);
        check("p1_req_ready", bus.p1_req_ready, want1);
        if (want0 || want1) model_accept(want1);
      end
    end
  end

  // Monitor: compares every presented response against the head of the scoreboard.
  always @(negedge clock) begin
    resp_t e;
    bit    p;
    if (reset_n && run && (bus.p0_resp_valid || bus.p1_resp_valid)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: actual=valid required=no response pending");
      end else begin
        e = exp_q[0];
        p = bus.p1_resp_valid;
        check("resp_port", p, e.port);
        check("resp_rdata", p ? bus.p1_resp_rdata : bus.p0_resp_rdata, e.rdata);
        check("resp_err", p ? bus.p1_resp_err : bus.p0_resp_err, e.err);
        check("idle_port_rdata", p ? bus.p0_resp_rdata : bus.p1_resp_rdata, 0);
        check("idle_port_err", p ? bus.p0_resp_err : bus.p1_resp_err, 0);
        if (p ? bus.p1_resp_ready : bus.p0_resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " p0_req_ready"}, bus.p0_req_ready, 0);
    check({tag, " p1_req_ready"}, bus.p1_req_ready, 0);
    check({tag, " p0_resp_valid"}, bus.p0_resp_valid, 0);
    check({tag, " p1_resp_valid"}, bus.p1_resp_valid, 0);
    check({tag, " p0_resp_rdata"}, bus.p0_resp_rdata, 0);
    check({tag, " p1_resp_rdata"}, bus.p1_resp_rdata, 0);
    check({tag, " p0_resp_err"}, bus.p0_resp_err, 0);
    check({tag, " p1_resp_err"}, bus.p1_resp_err, 0);
    check({tag, " mem_r_enable"}, bus.mem_r_enable, 0);
    check({tag, " mem_w_enable"}, bus.mem_w_enable, 0);
    check({tag, " mem_r_index"}, bus.mem_r_index, 0);
    check({tag, " mem_w_index"}, bus.mem_w_index, 0);
    check({tag, " mem_w_data"}, bus.mem_w_data, 0);
    check({tag, " mem_w_mask"}, bus.mem_w_mask, 0);
  endtask

  // mode 0: only queued directed requests; 1: sparse random; 2: both ports always requesting.
  task automatic step(input int mode);
    req1_t r;
    @(posedge clock);
    #1;
    if (acc0 != seen0) begin bus.p0_req_valid = 1'b0; seen0 = acc0; end
    if (acc1 != seen1) begin bus.p1_req_valid = 1'b0; seen1 = acc1; end
    if (!bus.p0_req_valid) begin
      if (dir0.size() > 0) begin
        bus.p0_req_addr  = dir0.pop_front();
        bus.p0_req_valid = 1'b1;
      end else if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) begin
        bus.p0_req_addr  = rand_addr();
        bus.p0_req_valid = 1'b1;
      end
    end
    if (!bus.p1_req_valid) begin
      if (dir1.size() > 0) begin
        r = dir1.pop_front();
        bus.p1_req_valid = 1'b1;
      end else if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) begin
        r.addr  = rand_addr();
        r.wen   = 1'($urandom_range(0, 1));
        r.wdata = {$urandom, $urandom};
        r.wstrb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        bus.p1_req_valid = 1'b1;
      end
      if (bus.p1_req_valid) begin
        bus.p1_req_addr  = r.addr;
        bus.p1_req_wen   = r.wen;
        bus.p1_req_wdata = r.wdata;
        bus.p1_req_wstrb = r.wstrb;
      end
    end
    if (hold_cnt > 0) begin
      hold_cnt--;
      bus.p0_resp_ready = 1'b0;
      bus.p1_resp_ready = 1'b0;
    end else if ($urandom_range(0, 15) == 0) begin
      hold_cnt = 5;
      bus.p0_resp_ready = 1'b0;
      bus.p1_resp_ready = 1'b0;
    end else begin
      bus.p0_resp_ready = ($urandom_range(0, 3) != 0);
      bus.p1_resp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    int left;
    for (int i = 0; i < 300; i++) begin
      if (!busy && exp_q.size() == 0 && !bus.p0_req_valid && !bus.p1_req_valid) break;
      step(0);
    end
    left = exp_q.size() + int'(busy) + int'(bus.p0_req_valid) + int'(bus.p1_req_valid);
    check("drain_outstanding", left, 0);
  endtask

  initial begin
    bit found;
    bus.p0_req_valid = 1'b1;
    bus.p0_req_addr  = '0;
    bus.p0_resp_ready = 1'b0;
    bus.p1_req_valid = 1'b1;
    bus.p1_req_wen   = 1'b0;
    bus.p1_req_addr  = '0;
    bus.p1_req_wdata = '0;
    bus.p1_req_wstrb = '0;
    bus.p1_resp_ready = 1'b0;

    repeat (2) @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1;
    bus.p0_req_valid = 1'b0;
    bus.p1_req_valid = 1'b0;
    reset_n = 1'b1;
    run = 1'b1;

    dir0.push_back(64'h0000_0000_8000_0010);
    dir1.push_back('{64'h0000_0000_8000_0008, 1'b1, 64'h1122_3344_5566_7788, 8'h0F});
    dir1.push_back('{64'h0000_0000_7FFF_FFF8, 1'b0, 64'h0, 8'h00});
    dir1.push_back('{64'h0000_0001_0000_0000, 1'b0, 64'h0, 8'h00});
    dir1.push_back('{64'h0000_0000_8000_0008, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 8'h00});
    dir1.push_back('{64'h0000_0000_8000_000F, 1'b0, 64'h0, 8'h00});

    repeat (1500) step(1);
    repeat (1000) step(2);
    drain();

    dir1.push_back('{64'h0000_0000_8000_0040, 1'b0, 64'h0, 8'h00});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0);
      if (busy && phase == 0 && cur_port) found = 1'b1;
    end
    check("reached_access_before_reset", found, 1);
    run = 1'b0;
    check("mem_r_enable_before_reset", bus.mem_r_enable, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    bus.p0_req_valid = 1'b0;
    bus.p1_req_valid = 1'b0;
    seen0 = acc0;
    seen1 = acc1;
    hold_cnt = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    run = 1'b1;

    dir0.push_back(64'h0000_0000_8000_0040);
    dir1.push_back('{64'h0000_0000_8000_0048, 1'b0, 64'h0, 8'h00});
    repeat (300) step(1);
    repeat (200) step(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
